id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage RISC-V core, with integrated load-use hazard detection, bubble insertion and branch flush.
- Its registered ex_rs1/ex_rs2 feed the EX-stage forwarding unit, which compares them against the EX/MEM and MEM/WB destination registers.
- Holds the stall/bubble decisions that forwarding alone cannot resolve, which is the load-data-into-next-instruction case.

---
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush and a saturating count of inserted load-use bubbles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             id_alusrc,
  input  logic [1:0]       id_aluop,
  input  logic             flush,
  input  logic             ex_hold,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rd1,
  output logic [XLEN-1:0]  ex_rd2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg,
  output logic             ex_alusrc,
  output logic [1:0]       ex_aluop,
  output logic             id_stall,
  output logic [CNT_W-1:0] stall_count
);

  // All EX-side state is kept as one record so a bubble is simply all-zero.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            alusrc;
    logic [1:0]      aluop;
  } stage_t;

  stage_t stage_q;
  stage_t capture;
  logic   rs1_hit;
  logic   rs2_hit;
  logic   load_use;

  // A load in EX whose destination is read by the decode instruction cannot
  // be forwarded in time; x0 is never a real producer.
  assign rs1_hit  = id_uses_rs1 && (stage_q.rd == id_rs1);
  assign rs2_hit  = id_uses_rs2 && (stage_q.rd == id_rs2);
  assign load_use = stage_q.valid && stage_q.memread && (stage_q.rd != 5'd0) &&
                    id_valid && (rs1_hit || rs2_hit);

  // A flush kills the decode slot, so the front end must never be frozen then.
  assign id_stall = !flush && (ex_hold || load_use);

  // Decode fields to load on a normal advance; an invalid slot becomes a bubble.
  always_comb begin
    capture = '0;
    if (id_valid) begin
      capture.valid    = 1'b1;
      capture.pc       = id_pc;
      capture.rd1      = id_rd1;
      capture.rd2      = id_rd2;
      capture.imm      = id_imm;
      capture.rs1      = id_rs1;
      capture.rs2      = id_rs2;
      capture.rd       = id_rd;
      capture.regwrite = id_regwrite;
      capture.memread  = id_memread;
      capture.memwrite = id_memwrite;
      capture.memtoreg = id_memtoreg;
      capture.alusrc   = id_alusrc;
      capture.aluop    = id_aluop;
    end
  end

  // Pipeline register: flush beats hold, hold beats load-use, else advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q <= '0;
    end else if (ex_hold) begin
      stage_q <= stage_q;
    end else if (load_use) begin
      stage_q <= '0;
    end else begin
      stage_q <= capture;
    end
  end

  // Count only bubbles actually inserted for load-use, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!flush && !ex_hold && load_use && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign ex_valid    = stage_q.valid;
  assign ex_pc       = stage_q.pc;
  assign ex_rd1      = stage_q.rd1;
  assign ex_rd2      = stage_q.rd2;
  assign ex_imm      = stage_q.imm;
  assign ex_rs1      = stage_q.rs1;
  assign ex_rs2      = stage_q.rs2;
  assign ex_rd       = stage_q.rd;
  assign ex_regwrite = stage_q.regwrite;
  assign ex_memread  = stage_q.memread;
  assign ex_memwrite = stage_q.memwrite;
  assign ex_memtoreg = stage_q.memtoreg;
  assign ex_alusrc   = stage_q.alusrc;
  assign ex_aluop    = stage_q.aluop;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized
// run, all compared against a behavioural model of the EX-side contents.
module tb_id_ex_stage;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_uses_rs1, id_uses_rs2;
  logic             id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc;
  logic [1:0]       id_aluop;
  logic             flush, ex_hold;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic             ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
  logic [1:0]       ex_aluop;
  logic             id_stall;
  logic [CNT_W-1:0] stall_count;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            alusrc;
    logic [1:0]      aluop;
  } ex_t;

  ex_t dut_ex;
  ex_t mdl;
  ex_t snap;
  int  mdl_cnt;
  int  checks = 0;
  int  errors = 0;
  logic exp_stall;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_aluop(id_aluop),
    .flush(flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .id_stall(id_stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign dut_ex = {ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                   ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_aluop};

  // Reference: a load in EX feeding a register the decode instruction really reads.
  function automatic logic model_load_use();
    return mdl.valid && mdl.memread && (mdl.rd != 0) && id_valid &&
           ((id_uses_rs1 && mdl.rd == id_rs1) || (id_uses_rs2 && mdl.rd == id_rs2));
  endfunction

  function automatic logic model_stall();
    return !flush && (ex_hold || model_load_use());
  endfunction

  // Reference: one clock edge of the stage, in priority order.
  task automatic model_edge();
    logic lu;
    lu = model_load_use();
    if (flush) mdl = '0;
    else if (ex_hold) mdl = mdl;
    else if (lu) begin
      mdl = '0;
      if (mdl_cnt < CNT_MAX) mdl_cnt = mdl_cnt + 1;
    end else if (!id_valid) mdl = '0;
    else mdl = '{valid: 1'b1, pc: id_pc, rd1: id_rd1, rd2: id_rd2, imm: id_imm,
                 rs1: id_rs1, rs2: id_rs2, rd: id_rd, regwrite: id_regwrite,
                 memread: id_memread, memwrite: id_memwrite, memtoreg: id_memtoreg,
                 alusrc: id_alusrc, aluop: id_aluop};
  endtask

  // Advance one edge; inputs stay put until #1 after it.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_pc = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    id_alusrc = 0; id_aluop = 0; flush = 0; ex_hold = 0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    set_idle();
    id_valid = 1; id_pc = 32'h200; id_rd = rd; id_rs1 = 5'd2; id_uses_rs1 = 1;
    id_imm = 32'h10; id_regwrite = 1; id_memread = 1; id_memtoreg = 1; id_alusrc = 1;
  endtask

  task automatic set_alu(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd);
    set_idle();
    id_valid = 1; id_pc = 32'h204; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1;
    id_uses_rs2 = u2; id_rd = rd; id_rd1 = 32'hAAAA; id_rd2 = 32'h5555;
    id_regwrite = 1; id_aluop = 2'd2;
  endtask

  task automatic do_reset();
    rst = 1;
    mdl = '0;
    mdl_cnt = 0;
    #1;
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    @(negedge clk);
    rst = 1; mdl = '0; mdl_cnt = 0;
    #1;
    checks++;
    if (dut_ex !== '0 || stall_count !== '0 || id_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset: ex=%h cnt=%0d stall=%b, required all zero", dut_ex, stall_count, id_stall);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_capture();
    set_idle();
    id_valid = 1; id_pc = 32'h100; id_rd = 5'd3; id_regwrite = 1;
    #1;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_rd !== 5'd3 || ex_regwrite !== 1'b1 || id_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL capture: valid=%b pc=%h rd=%0d rw=%b stall=%b, required 1 100 3 1 0",
               ex_valid, ex_pc, ex_rd, ex_regwrite, id_stall);
    end
    checks++;
    if (dut_ex !== mdl) begin
      errors++;
      $display("[TB] FAIL capture_model: got %h, required %h", dut_ex, mdl);
    end
  endtask

  task automatic test_load_use();
    int cnt0;
    set_load(5'd5);
    tick();
    cnt0 = mdl_cnt;
    set_alu(5'd5, 5'd7, 1, 1, 5'd6);
    #1;
    checks++;
    if (id_stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lu_stall: got %b, required 1", id_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_memread !== 1'b0 || int'(stall_count) != cnt0 + 1 || dut_ex !== mdl) begin
      errors++;
      $display("[TB] FAIL lu_bubble: valid=%b rd=%0d cnt=%0d, required 0 0 %0d", ex_valid, ex_rd, stall_count, cnt0 + 1);
    end
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lu_one_cycle: stall=%b, required 0", id_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_rd !== 5'd6 || dut_ex !== mdl) begin
      errors++;
      $display("[TB] FAIL lu_capture: valid=%b rs1=%0d rd=%0d, required 1 5 6", ex_valid, ex_rs1, ex_rd);
    end
  endtask

  task automatic test_no_stall();
    int cnt0;
    // Load to x0 never stalls a reader of x0.
    set_load(5'd0);
    tick();
    cnt0 = mdl_cnt;
    set_alu(5'd0, 5'd0, 1, 1, 5'd8);
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL x0_stall: got %b, required 0", id_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd8 || int'(stall_count) != cnt0) begin
      errors++;
      $display("[TB] FAIL x0_capture: valid=%b rd=%0d cnt=%0d, required 1 8 %0d", ex_valid, ex_rd, stall_count, cnt0);
    end
    // Matching rs2 that the instruction does not read.
    set_load(5'd5);
    tick();
    set_alu(5'd9, 5'd5, 1, 0, 5'd10);
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unused_rs2_stall: got %b, required 0", id_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || int'(stall_count) != cnt0 || dut_ex !== mdl) begin
      errors++;
      $display("[TB] FAIL unused_rs2_capture: valid=%b rd=%0d cnt=%0d, required 1 10 %0d", ex_valid, ex_rd, stall_count, cnt0);
    end
  endtask

  task automatic test_flush_load_use();
    int cnt0;
    set_load(5'd5);
    tick();
    cnt0 = mdl_cnt;
    set_alu(5'd5, 5'd0, 1, 0, 5'd11);
    flush = 1;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_stall: got %b, required 0", id_stall);
    end
    tick();
    checks++;
    if (dut_ex !== '0 || int'(stall_count) != cnt0) begin
      errors++;
      $display("[TB] FAIL flush_bubble: ex=%h cnt=%0d, required zero and %0d", dut_ex, stall_count, cnt0);
    end
    // Flush also overrides hold.
    set_alu(5'd1, 5'd2, 1, 1, 5'd12);
    tick();
    flush = 1; ex_hold = 1;
    #1;
    tick();
    checks++;
    if (dut_ex !== '0) begin
      errors++;
      $display("[TB] FAIL flush_over_hold: ex=%h, required zero", dut_ex);
    end
  endtask

  task automatic test_hold();
    int cnt0;
    set_load(5'd5);
    tick();
    snap = mdl;
    cnt0 = mdl_cnt;
    set_alu(5'd4, 5'd5, 1, 1, 5'd13);
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (id_stall !== 1'b1) begin
        errors++;
        $display("[TB] FAIL hold_stall[%0d]: got %b, required 1", i, id_stall);
      end
      tick();
      checks++;
      if (dut_ex !== snap || int'(stall_count) != cnt0) begin
        errors++;
        $display("[TB] FAIL hold_frozen[%0d]: ex=%h cnt=%0d, required %h %0d", i, dut_ex, stall_count, snap, cnt0);
      end
    end
    ex_hold = 0;
    #1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || dut_ex !== mdl || int'(stall_count) != ((cnt0 < CNT_MAX) ? cnt0 + 1 : CNT_MAX)) begin
      errors++;
      $display("[TB] FAIL hold_release_bubble: ex=%h cnt=%0d", dut_ex, stall_count);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd13 || dut_ex !== mdl) begin
      errors++;
      $display("[TB] FAIL hold_release_capture: valid=%b rd=%0d, required 1 13", ex_valid, ex_rd);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    set_idle();
    do_reset();
    for (int p = 0; p < 5; p++) begin
      set_load(5'd7);
      tick();
      set_alu(5'd7, 5'd7, 1, 1, 5'd14);
      #1;
      tick();
      checks++;
      if (int'(stall_count) != exp_cnt[p] || mdl_cnt != exp_cnt[p]) begin
        errors++;
        $display("[TB] FAIL sat_count[%0d]: got %0d, required %0d", p, stall_count, exp_cnt[p]);
      end
      tick();
    end
    // Reset mid-stall clears everything without waiting for an edge.
    set_load(5'd7);
    tick();
    set_alu(5'd7, 5'd0, 1, 0, 5'd15);
    #1;
    rst = 1; mdl = '0; mdl_cnt = 0;
    #1;
    checks++;
    if (dut_ex !== '0 || stall_count !== '0 || id_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: ex=%h cnt=%0d stall=%b, required zero", dut_ex, stall_count, id_stall);
    end
    @(negedge clk);
    rst = 0;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd15 || stall_count !== '0 || dut_ex !== mdl) begin
      errors++;
      $display("[TB] FAIL post_reset_capture: valid=%b rd=%0d cnt=%0d, required 1 15 0", ex_valid, ex_rd, stall_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      id_valid    = ($urandom % 4) != 0;
      id_pc       = $urandom;
      id_rd1      = $urandom;
      id_rd2      = $urandom;
      id_imm      = $urandom;
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rd       = 5'($urandom_range(0, 3));
      id_uses_rs1 = $urandom % 2;
      id_uses_rs2 = $urandom % 2;
      id_regwrite = $urandom % 2;
      id_memread  = $urandom % 2;
      id_memwrite = $urandom % 2;
      id_memtoreg = $urandom % 2;
      id_alusrc   = $urandom % 2;
      id_aluop    = 2'($urandom);
      flush       = ($urandom % 8) == 0;
      ex_hold     = ($urandom % 6) == 0;
      #1;
      exp_stall = model_stall();
      checks++;
      if (id_stall !== exp_stall) begin
        errors++;
        $display("[TB] FAIL rand_stall[%0d]: got %b, required %b", n, id_stall, exp_stall);
      end
      tick();
      checks++;
      if (dut_ex !== mdl || int'(stall_count) != mdl_cnt) begin
        errors++;
        $display("[TB] FAIL rand_state[%0d]: ex=%h cnt=%0d, required %h %0d", n, dut_ex, stall_count, mdl, mdl_cnt);
      end
    end
  endtask

  initial begin
    rst = 0;
    mdl = '0;
    mdl_cnt = 0;
    set_idle();
    test_reset();
    test_capture();
    test_load_use();
    test_no_stall();
    test_flush_load_use();
    test_hold();
    test_saturation();
    set_idle();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
